// File: rtl/multi_range_counter.sv
// Multi-channel range counter: each channel watches a shared counter and opens a
// window of a programmable number of enabled ticks after the counter hits its start.
module multi_range_counter #(
  parameter int unsigned channels      = 4,
  parameter int unsigned counter_width = 10,
  parameter int unsigned elapsed_width = 4,
  // Derived from channels; not meant to be overridden.
  parameter int unsigned chan_width    = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              load,
  input  logic [chan_width-1:0]             load_channel,
  input  logic [counter_width-1:0]          load_start,
  input  logic [elapsed_width-1:0]          load_length,
  input  logic                              load_repeat,
  input  logic [counter_width-1:0]          counter,
  input  logic                              enable,
  output logic [channels-1:0]               active,
  output logic [channels*elapsed_width-1:0] elapsed,
  output logic [channels-1:0]               done
);

  typedef enum logic {StIdle, StActive} state_e;

  for (genvar i = 0; i < channels; i++) begin : g_chan
    logic [counter_width-1:0] start_q;
    logic [elapsed_width-1:0] length_q;
    logic [elapsed_width-1:0] elapsed_q;
    logic                     repeat_q;
    logic                     armed_q;
    logic                     done_q;
    state_e                   state_q;

    logic sel;
    logic match;
    logic last;

    // An out-of-range load_channel never equals any channel index, so it is ignored.
    assign sel   = load && (load_channel == chan_width'(i));
    assign match = armed_q && enable && (counter == start_q) && (length_q != '0);
    assign last  = (elapsed_q == length_q - elapsed_width'(1));

    // Per-channel window FSM; a load takes priority and aborts any open window.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        start_q   <= '0;
        length_q  <= '0;
        repeat_q  <= 1'b0;
        armed_q   <= 1'b0;
        elapsed_q <= '0;
        done_q    <= 1'b0;
        state_q   <= StIdle;
      end else begin
        done_q <= 1'b0;
        if (sel) begin
          start_q   <= load_start;
          length_q  <= load_length;
          repeat_q  <= load_repeat;
          armed_q   <= (load_length != '0);
          elapsed_q <= '0;
          state_q   <= StIdle;
        end else begin
          unique case (state_q)
            StIdle: begin
              if (match) begin
                state_q   <= StActive;
                elapsed_q <= '0;
              end
            end
            StActive: begin
              if (enable) begin
                if (last) begin
                  state_q   <= StIdle;
                  elapsed_q <= '0;
                  done_q    <= 1'b1;
                  // One-shot channels disarm until reloaded.
                  if (!repeat_q) armed_q <= 1'b0;
                end else begin
                  elapsed_q <= elapsed_q + elapsed_width'(1);
                end
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end

    // Outputs are straight register taps.
    always_comb begin
      active[i]                                 = (state_q == StActive);
      elapsed[i*elapsed_width +: elapsed_width] = elapsed_q;
      done[i]                                   = done_q;
    end
  end

endmodule
